// File: rtl/barrel_shifter_left_seq_32b.sv
// Sequential 32-bit logical left shifter that applies one power-of-two stage per BUSY cycle.
// Latency: the result is valid just after the 5th edge following an accept, for any shift amount.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
module barrel_shifter_left_seq_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic [4:0]  cntrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] data, data_nxt;
  logic [4:0]  amt, amt_nxt;
  logic [2:0]  stage, stage_nxt;
  logic [31:0] stage_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      data  <= 32'd0;
      amt   <= 5'd0;
      stage <= 3'd0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      amt   <= amt_nxt;
      stage <= stage_nxt;
    end
  end

  // One mux level per cycle: stage k conditionally shifts by 2^k.
  always_comb begin
    stage_shift = data;
    case (stage)
      3'd0: if (amt[0]) stage_shift = {data[30:0], 1'b0};
      3'd1: if (amt[1]) stage_shift = {data[29:0], 2'b0};
      3'd2: if (amt[2]) stage_shift = {data[27:0], 4'b0};
      3'd3: if (amt[3]) stage_shift = {data[23:0], 8'b0};
      3'd4: if (amt[4]) stage_shift = {data[15:0], 16'b0};
      default: stage_shift = data;
    endcase
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    amt_nxt   = amt;
    stage_nxt = stage;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt  = in;
          amt_nxt   = cntrl;
          stage_nxt = 3'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (stage > 3'd4) begin
          // Corrupted stage counter: abandon the operation.
          stage_nxt = 3'd0;
          state_nxt = IDLE;
        end else begin
          data_nxt = stage_shift;
          if (stage == 3'd4) begin
            stage_nxt = 3'd0;
            state_nxt = DONE;
          end else begin
            stage_nxt = stage + 3'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        stage_nxt = 3'd0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so reset reaches them without a clock.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out       = out_valid ? data : 32'd0;

endmodule

// File: tb/tb_barrel_shifter_left_seq_32b.sv
// Directed and random checks for the sequential left barrel shifter.
module tb_barrel_shifter_left_seq_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_d = 32'd0;
  logic [4:0]  cntrl = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  barrel_shifter_left_seq_32b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_d),
    .cntrl     (cntrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_d)
  );

  typedef struct {
    logic [31:0] a;
    logic [4:0]  s;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at the negedge just after the accept edge; returns at the negedge where out_valid rises.
  task automatic wait_result(input string name, input logic [31:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({name, " gated"}, out_d, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, lat, 5);
    chk({name, " out"}, out_d, exp);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [4:0] s, input logic [31:0] exp,
                       input string name);
    @(negedge clk);
    chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_d      = a;
    cntrl     = s;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_d     = $urandom;
    cntrl    = 5'($urandom);
    wait_result(name, exp);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int   acc[$];
    int   t;
    logic [31:0] a;
    logic [4:0]  s;

    vecs[0]  = '{32'h00000001, 5'd31, 32'h80000000};
    vecs[1]  = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[2]  = '{32'h12345678, 5'd4,  32'h23456780};
    vecs[3]  = '{32'hFFFFFFFF, 5'd16, 32'hFFFF0000};
    vecs[4]  = '{32'h00000001, 5'd5,  32'h00000020};
    vecs[5]  = '{32'h80000001, 5'd1,  32'h00000002};
    vecs[6]  = '{32'hA5A5A5A5, 5'd8,  32'hA5A5A500};
    vecs[7]  = '{32'h0000FFFF, 5'd31, 32'h80000000};
    vecs[8]  = '{32'h12345678, 5'd12, 32'h45678000};
    vecs[9]  = '{32'hF0F0F0F0, 5'd3,  32'h87878780};
    vecs[10] = '{32'h00000003, 5'd30, 32'hC0000000};
    vecs[11] = '{32'h7FFFFFFF, 5'd2,  32'hFFFFFFFC};

    // Reset values must be visible while rst is held, before any edge.
    #1;
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out", out_d, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].s, vecs[i].exp, $sformatf("vec%0d", i));

    // Backpressure with a competing operand waiting.
    @(negedge clk);
    in_valid  = 1'b1;
    in_d      = 32'h12345678;
    cntrl     = 5'd4;
    out_ready = 1'b0;
    @(negedge clk);
    in_d  = 32'hFFFFFFFF;
    cntrl = 5'd8;
    wait_result("bp", 32'h23456780);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold out %0d", k), out_d, 32'h23456780);
      chk($sformatf("bp hold in_ready %0d", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp hold out_valid %0d", k), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp idle in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp idle out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("bp next", 32'hFFFFFF00);

    // Operand changes during BUSY must not leak into the result.
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 32'hFFFFFFFF;
    cntrl    = 5'd16;
    @(negedge clk);
    in_valid = 1'b0;
    in_d     = 32'h0;
    cntrl    = 5'd1;
    wait_result("busy change", 32'hFFFF0000);

    // Asynchronous reset in the middle of BUSY.
    @(negedge clk);
    in_valid = 1'b1;
    in_d     = 32'hAAAAAAAA;
    cntrl    = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid rst out", out_d, 32'd0);
    #1;
    rst      = 1'b0;
    in_valid = 1'b1;
    in_d     = 32'h00000001;
    cntrl    = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("post rst", 32'h00000020);

    // Throughput with both handshakes held high: accepts every 7 cycles.
    in_valid  = 1'b1;
    in_d      = 32'h00000010;
    cntrl     = 5'd2;
    out_ready = 1'b1;
    for (t = 0; t < 16; t++) begin
      @(negedge clk);
      if (in_ready) acc.push_back(t);
    end
    in_valid = 1'b0;
    chk("tput accepts", acc.size(), 3);
    if (acc.size() >= 3) begin
      chk("tput gap1", acc[1] - acc[0], 7);
      chk("tput gap2", acc[2] - acc[1], 7);
    end
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("tput drain", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 10000; n++) begin
      a = $urandom;
      s = 5'($urandom);
      do_op(a, s, a << s, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_shifter_left_seq_32b.md
BARREL_SHIFTER_LEFT_SEQ_32B -- requirements
Module: barrel_shifter_left_seq_32b

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL define no parameters.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand request.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in  input  32  value to shift.
REQ-007 cntrl  input  5  left shift amount, 0..31.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out  output  32  shifted result.

Function
REQ-011 The result SHALL equal (in << cntrl) mod 2^32, with zero fill from bit 0 (RISC-V SLL semantics), and there SHALL be no arithmetic mode.
- States: IDLE, BUSY, DONE.
- Registers: data[31:0], amt[4:0], stage[2:0].
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 out_valid SHALL be 1 only in DONE.
REQ-014 An accept (in_valid && in_ready at a rising edge) SHALL do all of the following:
- load data<=in, amt<=cntrl, stage<=0;
- move to BUSY.
REQ-015 In IDLE with in_valid=0, the state SHALL be held.
REQ-016 Each BUSY cycle SHALL process stage k=stage (0..4):
- if amt[k]=1, data <= data << 2^k; otherwise data is held;
- stage increments.
REQ-017 After stage 4 is processed, BUSY SHALL move to DONE, giving exactly 5 BUSY cycles per operation whatever cntrl is, including cntrl=0.
REQ-018 Latency: for an accept at edge E0, out_valid SHALL be 1 and out valid from just after E5.
REQ-019 In DONE, out SHALL equal data and SHALL be held stable while out_ready=0.
REQ-020 A DONE->IDLE transition SHALL occur at the first edge with out_ready=1, and in_ready SHALL be 0 in DONE, so an accept cannot coincide with the result handshake.
REQ-021 Maximum throughput SHALL be one operation per 7 cycles (accepts at E0 and E7 with in_valid and out_ready held high).
REQ-022 in, cntrl and in_valid SHALL be ignored outside IDLE, and changes during BUSY/DONE SHALL NOT affect the result.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 out SHALL be 0 whenever out_valid=0 (gated), so no intermediate stage values are visible.
REQ-025 stage SHALL never exceed 4, and unused encodings 5..7 SHALL force a return to IDLE.
REQ-026 Each 32-bit stage shift SHALL be a single-stage left mux of the data register, with no combinational path from in/cntrl to out.

Reset
REQ-027 While rst=1, all outputs SHALL assume reset values immediately, without waiting for a clock edge: state=IDLE, data=0, amt=0, stage=0, in_ready=1, out_valid=0, out=0.
REQ-028 Assertion of rst during BUSY or DONE SHALL abort the operation and discard its result.
REQ-029 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-030 Maximum shift: in=0x00000001, cntrl=31, out_ready=1 -> out_valid rises 5 cycles after accept, out=0x80000000.
REQ-031 Zero shift: in=0xDEADBEEF, cntrl=0 -> out=0xDEADBEEF, latency still 5 cycles.
REQ-032 Backpressure: in=0x12345678, cntrl=4, out_ready held 0 for 3 cycles in DONE, in_valid=1 with in=0xFFFFFFFF meanwhile -> out=0x23456780 stable and in_ready=0 for all 3 cycles; after out_ready=1, IDLE; the new operand is accepted only after returning to IDLE.
REQ-033 Input change during BUSY: in=0xFFFFFFFF, cntrl=16; in=0x0 and cntrl=1 applied during BUSY -> out=0xFFFF0000.
REQ-034 Mid-operation reset: rst pulsed in BUSY cycle 3 -> out_valid=0, out=0, in_ready=1 without a clock edge; next operation in=0x00000001, cntrl=5 -> out=0x00000020.
REQ-035 Throughput and self-checking: in_valid=1 and out_ready=1 continuously -> accepts at E0, E7, E14; 10,000 random in/cntrl pairs each compared against in<<cntrl, zero mismatches.
